// File: rtl/node_pkg.sv
`default_nettype none
// ============================================================================
// Module   : node_pkg
// Purpose  : Shared definitions for the sensor-node TDMA logic: scheduler
//            FSM state encoding and radio packet-type codes.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package node_pkg;

    // Scheduler FSM state encoding (visible on the state output)
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_SYNC = 2'd1;
    localparam logic [1:0] ST_RUN       = 2'd2;
    localparam logic [1:0] ST_TX        = 2'd3;

    // Packet-type field codes
    localparam logic [2:0] PKT_HB       = 3'b000;
    localparam logic [2:0] PKT_CH       = 3'b001;
    localparam logic [2:0] PKT_TIMESLOT = 3'b100;
    localparam logic [2:0] PKT_DATA     = 3'b101;

endpackage : node_pkg
`default_nettype wire

// File: rtl/slot_counter.sv
`default_nettype none
// ============================================================================
// Module   : slot_counter
// Purpose  : Cycle-in-slot and slot-in-frame counters for the TDMA
//            scheduler, with wrap logic and a registered frame_end pulse.
// Ports    : clk, nrst       - clock, synchronous active-low reset
//            clr            - zero both counters at the next edge
//            active_nxt     - scheduler will be in RUN/TX after this edge
//            num_slots_eff  - slots per frame (never 0)
//            slot_idx       - current slot
//            cyc_first      - cycle counter is 0
//            cyc_last       - cycle counter is SLOT_LEN-1
//            frame_end      - registered, high in the last cycle of a frame
// Revision : 1.0 - initial release
// ============================================================================
module slot_counter #(
    parameter int SLOT_LEN = 16,
    parameter int W        = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         clr,
    input  logic         active_nxt,
    input  logic [W-1:0] num_slots_eff,
    output logic [W-1:0] slot_idx,
    output logic         cyc_first,
    output logic         cyc_last,
    output logic         frame_end
);

    localparam int            CW     = $clog2(SLOT_LEN);
    localparam logic [CW-1:0] c_last = CW'(SLOT_LEN - 1);

    logic [CW-1:0] r_cyc;
    logic [W-1:0]  r_slot;
    logic          r_frame_end;
    logic [CW-1:0] w_cyc_nxt;
    logic [W-1:0]  w_slot_nxt;
    logic [W-1:0]  w_slot_max;
    logic          w_frame_end_nxt;

    assign w_slot_max = num_slots_eff - W'(1);

    always_comb begin
        w_cyc_nxt  = r_cyc;
        w_slot_nxt = r_slot;
        if (clr) begin
            w_cyc_nxt  = '0;
            w_slot_nxt = '0;
        end else if (r_cyc == c_last) begin
            w_cyc_nxt  = '0;
            w_slot_nxt = (r_slot == w_slot_max) ? '0 : r_slot + W'(1);
        end else begin
            w_cyc_nxt  = r_cyc + CW'(1);
        end
    end

    // frame_end is computed from the post-edge counter values so the
    // registered pulse lines up with the last cycle rather than trailing it.
    assign w_frame_end_nxt = active_nxt && (w_cyc_nxt == c_last) &&
                             (w_slot_nxt == w_slot_max);

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_cyc       <= '0;
            r_slot      <= '0;
            r_frame_end <= 1'b0;
        end else begin
            r_cyc       <= w_cyc_nxt;
            r_slot      <= w_slot_nxt;
            r_frame_end <= w_frame_end_nxt;
        end
    end

    assign slot_idx  = r_slot;
    assign cyc_first = (r_cyc == '0);
    assign cyc_last  = (r_cyc == c_last);
    assign frame_end = r_frame_end;

endmodule : slot_counter
`default_nettype wire

// File: rtl/node_tdma_sched.sv
`default_nettype none
// ============================================================================
// Module   : node_tdma_sched
// Purpose  : Per-node TDMA transmit scheduler. Latches the slot assignment
//            from a timeslot packet, aligns to the cluster-head beacon and
//            grants the radio for one slot per frame when data is pending.
// Ports    : clk, nrst          - clock, synchronous active-low reset
//            sched_en           - my_slot/num_slots valid (timeslot packet)
//            my_slot, num_slots - slot assignment and frame length
//            role               - 1 = cluster head (never schedules)
//            low_E              - low energy, suppresses grants
//            sync_i             - frame-start beacon pulse
//            sched_clr          - abandon schedule (new round)
//            data_pending       - packet queued
//            tx_done            - packet generator finished
//            tx_grant           - transmit permission (registered)
//            slot_idx           - current slot
//            frame_end          - pulse in last cycle of frame (registered)
//            overrun            - pulse when slot expired during TX
//            cfg_err            - sticky illegal-configuration flag
//            state              - FSM state
// Revision : 1.0 - initial release
// ============================================================================
module node_tdma_sched
    import node_pkg::*;
#(
    parameter int SLOT_LEN = 16,
    parameter int W        = 16
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic         sched_en,
    input  logic [W-1:0] my_slot,
    input  logic [W-1:0] num_slots,
    input  logic         role,
    input  logic         low_E,
    input  logic         sync_i,
    input  logic         sched_clr,
    input  logic         data_pending,
    input  logic         tx_done,
    output logic         tx_grant,
    output logic [W-1:0] slot_idx,
    output logic         frame_end,
    output logic         overrun,
    output logic         cfg_err,
    output logic [1:0]   state
);

    logic [1:0]   r_state;
    logic [1:0]   w_state_nxt;
    logic [W-1:0] r_my_slot;
    logic [W-1:0] r_num_slots;
    logic         r_tx_grant;
    logic         r_overrun;
    logic         r_cfg_err;

    logic [W-1:0] w_eff_in;
    logic         w_cfg_bad;
    logic         w_accept;
    logic         w_active;
    logic         w_active_nxt;
    logic         w_cnt_clr;
    logic         w_tx_grant_nxt;
    logic         w_overrun_nxt;
    logic         w_cfg_err_nxt;
    logic [W-1:0] w_slot_idx;
    logic         w_cyc_first;
    logic         w_cyc_last;
    logic         w_frame_end;

    // A zero-length frame is meaningless; run it as a single slot.
    assign w_eff_in  = (num_slots == '0) ? W'(1) : num_slots;
    assign w_cfg_bad = (my_slot >= w_eff_in);
    assign w_accept  = !sched_clr && (r_state == ST_IDLE) && sched_en && !role;
    assign w_active  = (r_state == ST_RUN) || (r_state == ST_TX);
    assign w_active_nxt = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_TX);

    // Counters idle at zero outside RUN/TX; a beacon realigns them.
    assign w_cnt_clr = sched_clr || sync_i || !w_active;

    // ---------------------------------------------------------------- state reg
    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // --------------------------------------------------------------- next state
    always_comb begin
        w_state_nxt = r_state;
        if (sched_clr) begin
            w_state_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (sched_en && !role && !w_cfg_bad)
                        w_state_nxt = ST_WAIT_SYNC;
                end
                ST_WAIT_SYNC: begin
                    if (sync_i)
                        w_state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    // Grant is decided only at the first cycle of our slot;
                    // missing it forfeits the slot for this frame.
                    if (sync_i)
                        w_state_nxt = ST_RUN;
                    else if (w_cyc_first && (w_slot_idx == r_my_slot) &&
                             data_pending && !low_E)
                        w_state_nxt = ST_TX;
                end
                ST_TX: begin
                    if (sync_i || tx_done || w_cyc_last)
                        w_state_nxt = ST_RUN;
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------ output logic
    always_comb begin
        w_tx_grant_nxt = (w_state_nxt == ST_TX);
        // Expiry only counts as overrun when nothing of higher priority
        // (clear, beacon, completion) claims the same cycle.
        w_overrun_nxt  = !sched_clr && (r_state == ST_TX) && !sync_i &&
                         !tx_done && w_cyc_last;
        w_cfg_err_nxt  = sched_clr ? 1'b0 : (r_cfg_err || (w_accept && w_cfg_bad));
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            r_tx_grant  <= 1'b0;
            r_overrun   <= 1'b0;
            r_cfg_err   <= 1'b0;
            r_my_slot   <= '0;
            r_num_slots <= '0;
        end else begin
            r_tx_grant <= w_tx_grant_nxt;
            r_overrun  <= w_overrun_nxt;
            r_cfg_err  <= w_cfg_err_nxt;
            if (w_accept) begin
                r_my_slot   <= my_slot;
                r_num_slots <= w_eff_in;
            end
        end
    end

    slot_counter #(
        .SLOT_LEN (SLOT_LEN),
        .W        (W)
    ) u_slot_counter (
        .clk           (clk),
        .nrst          (nrst),
        .clr           (w_cnt_clr),
        .active_nxt    (w_active_nxt),
        .num_slots_eff (r_num_slots),
        .slot_idx      (w_slot_idx),
        .cyc_first     (w_cyc_first),
        .cyc_last      (w_cyc_last),
        .frame_end     (w_frame_end)
    );

    assign tx_grant  = r_tx_grant;
    assign slot_idx  = w_slot_idx;
    assign frame_end = w_frame_end;
    assign overrun   = r_overrun;
    assign cfg_err   = r_cfg_err;
    assign state     = r_state;

endmodule : node_tdma_sched
`default_nettype wire

// File: tb/tb_node_tdma_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_node_tdma_sched
// Purpose  : Self-checking bench for node_tdma_sched. Inputs change on the
//            falling edge; a time-since-beacon reference model predicts the
//            post-edge outputs, which a monitor compares after each rising edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_node_tdma_sched;

    localparam int L  = 4;
    localparam int WW = 16;

    logic          clk = 1'b0;
    logic          nrst, sched_en, role, low_E, sync_i, sched_clr;
    logic          data_pending, tx_done;
    logic [WW-1:0] my_slot, num_slots;
    logic          tx_grant, frame_end, overrun, cfg_err;
    logic [WW-1:0] slot_idx;
    logic [1:0]    state;

    always #5 clk = ~clk;

    node_tdma_sched #(.SLOT_LEN(L), .W(WW)) dut (
        .clk(clk), .nrst(nrst), .sched_en(sched_en), .my_slot(my_slot),
        .num_slots(num_slots), .role(role), .low_E(low_E), .sync_i(sync_i),
        .sched_clr(sched_clr), .data_pending(data_pending), .tx_done(tx_done),
        .tx_grant(tx_grant), .slot_idx(slot_idx), .frame_end(frame_end),
        .overrun(overrun), .cfg_err(cfg_err), .state(state)
    );

    typedef struct {
        int grant; int slot; int fe; int ov; int err; int st;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: mode 0=idle 1=waiting for beacon 2=scheduled;
    // t counts cycles since the last beacon, so slot/cycle are t/L, t%L.
    int m_mode = 0, m_t = 0, m_ms = 0, m_ns = 1, m_err = 0, m_tx = 0;

    task automatic model_step();
        exp_t e;
        int   ov = 0;
        int   eff;
        if (!nrst) begin
            m_mode = 0; m_t = 0; m_ms = 0; m_ns = 1; m_err = 0; m_tx = 0;
        end else if (sched_clr) begin
            m_mode = 0; m_t = 0; m_err = 0; m_tx = 0;
        end else if (m_mode == 0) begin
            if (sched_en && !role) begin
                eff  = (num_slots == 0) ? 1 : int'(num_slots);
                m_ms = int'(my_slot);
                m_ns = eff;
                if (m_ms >= eff) m_err = 1;
                else             m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (sync_i) begin m_mode = 2; m_t = 0; m_tx = 0; end
        end else begin
            if (sync_i) begin
                m_t = 0; m_tx = 0;
            end else begin
                if (m_tx != 0) begin
                    if (tx_done) m_tx = 0;
                    else if (m_t % L == L - 1) begin m_tx = 0; ov = 1; end
                end else if ((m_t % L == 0) && ((m_t / L) % m_ns == m_ms) &&
                             data_pending && !low_E) begin
                    m_tx = 1;
                end
                m_t++;
            end
        end
        e.grant = m_tx;
        e.ov    = ov;
        e.err   = m_err;
        if (m_mode == 2) begin
            e.slot = (m_t / L) % m_ns;
            e.fe   = ((m_t % L == L - 1) && (e.slot == m_ns - 1)) ? 1 : 0;
            e.st   = m_tx ? 3 : 2;
        end else begin
            e.slot = 0;
            e.fe   = 0;
            e.st   = m_mode;
        end
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s @%0t: got %0d want %0d", nm, $time, act, exp_v);
        end
    endtask

    // Monitor: compares every presented cycle against the queued prediction.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("tx_grant",  int'(tx_grant),  e.grant);
                chk("slot_idx",  int'(slot_idx),  e.slot);
                chk("frame_end", int'(frame_end), e.fe);
                chk("overrun",   int'(overrun),   e.ov);
                chk("cfg_err",   int'(cfg_err),   e.err);
                chk("state",     int'(state),     e.st);
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            model_step();
        end
    endtask

    // Drives one cycle with the given pulses high, then drops them.
    task automatic pulse(input logic en, input logic sy, input logic cl,
                         input logic dn);
        @(negedge clk);
        sched_en = en; sync_i = sy; sched_clr = cl; tx_done = dn;
        model_step();
        @(negedge clk);
        sched_en = 1'b0; sync_i = 1'b0; sched_clr = 1'b0; tx_done = 1'b0;
        model_step();
    endtask

    initial begin
        nrst = 1'b0; sched_en = 1'b0; role = 1'b0; low_E = 1'b0;
        sync_i = 1'b0; sched_clr = 1'b0; data_pending = 1'b0; tx_done = 1'b0;
        my_slot = 16'd1; num_slots = 16'd3;
        step(3);
        @(negedge clk); nrst = 1'b1; model_step();

        // Grant in slot 1, then early completion
        data_pending = 1'b1;
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        step(4);
        pulse(0, 0, 0, 1);
        step(6);

        // No completion: overrun at slot expiry, frame_end cadence
        step(40);

        // Completion coinciding with expiry
        step(7);
        pulse(0, 0, 0, 1);
        step(10);

        // Low energy: no grants
        low_E = 1'b1;
        step(40);
        low_E = 1'b0;

        // Cluster head: never leaves IDLE
        pulse(0, 0, 1, 0);
        role = 1'b1;
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        step(36);
        role = 1'b0;

        // Illegal assignment then clear
        my_slot = 16'd3;
        pulse(1, 0, 0, 0);
        step(3);
        pulse(0, 0, 1, 0);
        my_slot = 16'd1;

        // Beacon mid-TX, then clear together with beacon
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        step(4);
        pulse(0, 1, 0, 0);
        step(4);
        pulse(0, 1, 1, 0);
        step(3);

        // Reset mid-TX
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        step(4);
        @(negedge clk); nrst = 1'b0; model_step();
        @(negedge clk); nrst = 1'b1; model_step();
        step(3);

        // num_slots=0 acts as a single-slot frame
        my_slot = 16'd0; num_slots = 16'd0;
        pulse(1, 0, 0, 0);
        pulse(0, 1, 0, 0);
        step(20);
        pulse(0, 0, 1, 0);

        // Randomized traffic
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            nrst         = ($urandom_range(0, 299) != 0);
            sched_en     = ($urandom_range(0, 19) == 0);
            my_slot      = 16'($urandom_range(0, 3));
            num_slots    = 16'($urandom_range(0, 3));
            role         = ($urandom_range(0, 7) == 0);
            low_E        = ($urandom_range(0, 5) == 0);
            sync_i       = ($urandom_range(0, 29) == 0);
            sched_clr    = ($urandom_range(0, 99) == 0);
            data_pending = ($urandom_range(0, 2) != 0);
            tx_done      = ($urandom_range(0, 4) == 0);
            model_step();
        end
        @(negedge clk);
        nrst = 1'b1; sched_en = 1'b0; sync_i = 1'b0; sched_clr = 1'b0;
        tx_done = 1'b0;
        model_step();
        step(2);
        @(posedge clk);
        #2;
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_node_tdma_sched
`default_nettype wire
